// File: rtl/simd_cond_pkg.sv
// Shared types and the condition-code evaluator for the SIMD condition unit.
// Flag nibbles are laid out {N,Z,C,V}, MSB first, to match the ALU flag bus.
package simd_cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        RED_LANE0 = 2'b00,
        RED_ANY   = 2'b01,
        RED_ALL   = 2'b10,
        RED_RSVD  = 2'b11
    } reduce_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic logic eval_cond(nzcv_t f, cond_e cond);
        logic res;
        case (cond)
            COND_EQ: res = f.z;
            COND_NE: res = !f.z;
            COND_CS: res = f.c;
            COND_CC: res = !f.c;
            COND_MI: res = f.n;
            COND_PL: res = !f.n;
            COND_VS: res = f.v;
            COND_VC: res = !f.v;
            COND_HI: res = f.c & !f.z;
            COND_LS: res = !f.c | f.z;
            COND_GE: res = (f.n == f.v);
            COND_LT: res = (f.n != f.v);
            COND_GT: res = !f.z & (f.n == f.v);
            COND_LE: res = f.z | (f.n != f.v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lane_flag_reg.sv
// One lane's NZCV register with a sticky valid bit and the optional
// same-cycle bypass of incoming ALU flags into the evaluation path.
module lane_flag_reg #(
    parameter int BYPASS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       flush,
    input  logic       flag_write,
    input  logic [3:0] alu_flags,
    output logic [3:0] flags,
    output logic       valid,
    output logic [3:0] eff_flags
);

    logic [3:0] flags_reg;
    logic       valid_reg;

    // valid is sticky: once a lane has been written it stays valid until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_reg <= 4'b0000;
            valid_reg <= 1'b0;
        end else if (en && !flush && flag_write) begin
            flags_reg <= alu_flags;
            valid_reg <= 1'b1;
        end
    end

    assign flags     = flags_reg;
    assign valid     = valid_reg;
    assign eff_flags = ((BYPASS != 0) && flag_write) ? alu_flags : flags_reg;

endmodule

// File: rtl/simd_condition_unit.sv
// Per-lane NZCV storage and condition evaluation; produces a per-lane mask
// for predicated vector ops and a reduced scalar result for branches.
module simd_condition_unit
    import simd_cond_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int PIPE   = 1,
    parameter int BYPASS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic [LANES-1:0]   FlagWrite,
    input  logic [4*LANES-1:0] ALUFlags,
    input  logic               Branch,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Reduce,
    output logic [LANES-1:0]   LaneMask,
    output logic               CondEx,
    output logic [4*LANES-1:0] Flags
);

    cond_e            cond_code;
    reduce_e          reduce_mode;
    logic [LANES-1:0] lane_valid;
    logic [LANES-1:0] m;
    logic             c;

    assign cond_code   = cond_e'(Cond);
    assign reduce_mode = reduce_e'(Reduce);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [3:0] eff;

            lane_flag_reg #(
                .BYPASS(BYPASS)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .flush     (flush),
                .flag_write(FlagWrite[gi]),
                .alu_flags (ALUFlags[4*gi +: 4]),
                .flags     (Flags[4*gi +: 4]),
                .valid     (lane_valid[gi]),
                .eff_flags (eff)
            );

            // an unwritten lane only passes AL
            assign m[gi] = eval_cond(nzcv_t'(eff), cond_code)
                         & (lane_valid[gi] | (cond_code == COND_AL));
        end
    endgenerate

    always_comb begin
        c = 1'b1;
        if (Branch) begin
            case (reduce_mode)
                RED_ANY: c = |m;
                RED_ALL: c = &m;
                default: c = m[0];
            endcase
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic [LANES-1:0] mask_reg;
            logic             cex_reg;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    mask_reg <= '0;
                    cex_reg  <= 1'b0;
                end else if (en) begin
                    mask_reg <= m;
                    cex_reg  <= c;
                end
            end

            assign LaneMask = mask_reg;
            assign CondEx   = cex_reg;
        end else begin : g_comb
            assign LaneMask = m;
            assign CondEx   = c;
        end
    endgenerate

endmodule
